// File: rtl/uart_sync_hunter.sv
// uart_sync_hunter: sync-word hunt/verify/lock over a shifted bit window; all outputs registered, 1 cycle after the en bit.
// No backpressure: one bit accepted per en cycle. Define UART_SYNC_HUNTER_STATS_EN to add slip_cnt/hit_cnt/last_err.
module uart_sync_hunter #(
  parameter int SYNC_WIDTH = 16,
  parameter int FRAME_BITS = 64,
  parameter int LOCK_CNT   = 3,
  parameter int LOSS_CNT   = 2,
  parameter int MAX_ERR    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  in_bit,
  input  logic [SYNC_WIDTH-1:0] ref_sync,
  input  logic [SYNC_WIDTH-1:0] ref_mask,
  output logic                  sync_hit,
  output logic                  frame_start,
  output logic                  locked,
  output logic                  hunting
`ifdef UART_SYNC_HUNTER_STATS_EN
  ,
  output logic [15:0]                     slip_cnt,
  output logic [15:0]                     hit_cnt,
  output logic [$clog2(SYNC_WIDTH+1)-1:0] last_err
`endif
);

  localparam int ERR_W  = $clog2(SYNC_WIDTH + 1);
  localparam int CNT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  localparam logic [ERR_W-1:0]  FILL_FULL = ERR_W'(SYNC_WIDTH);
  localparam logic [ERR_W-1:0]  FILL_OK   = ERR_W'(SYNC_WIDTH - 1);
  localparam logic [ERR_W-1:0]  FILL_ONE  = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_LIM   = ERR_W'((MAX_ERR > SYNC_WIDTH) ? SYNC_WIDTH : MAX_ERR);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);
  localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t                state;
  logic [SYNC_WIDTH-1:0] win;
  logic [ERR_W-1:0]      fill;
  logic [CNT_W-1:0]      bit_cnt;
  logic [GOOD_W-1:0]     good;
  logic [MISS_W-1:0]     miss;

  logic [SYNC_WIDTH-1:0] new_win;
  logic [SYNC_WIDTH-1:0] diff;
  logic [ERR_W-1:0]      err;
  logic [CNT_W-1:0]      next_cnt;
  logic                  win_ok;
  logic                  match;
  logic                  boundary;

  // The window counts as full when the bit arriving now is the SYNC_WIDTH-th one.
  always_comb begin
    new_win = {win[SYNC_WIDTH-2:0], in_bit};
    diff    = (new_win ^ ref_sync) & ref_mask;
    err     = '0;
    for (int i = 0; i < SYNC_WIDTH; i++) begin
      err = err + ERR_W'(diff[i]);
    end
    win_ok   = (fill >= FILL_OK);
    match    = en && win_ok && (err <= ERR_LIM);
    boundary = en && (bit_cnt == LAST_BIT);
    next_cnt = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_ONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_HUNT;
      win         <= '0;
      fill        <= '0;
      bit_cnt     <= '0;
      good        <= '0;
      miss        <= '0;
      sync_hit    <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      hunting     <= 1'b1;
    end else begin
      sync_hit    <= match;
      frame_start <= (state == ST_LOCKED) && boundary;
      if (en) begin
        win <= new_win;
        if (fill != FILL_FULL) begin
          fill <= fill + FILL_ONE;
        end
        case (state)
          ST_HUNT: begin
            if (match) begin
              bit_cnt <= '0;
              hunting <= 1'b0;
              if (LOCK_CNT == 1) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
                miss   <= '0;
              end else begin
                state <= ST_VERIFY;
                good  <= GOOD_ONE;
              end
            end else begin
              bit_cnt <= next_cnt;
            end
          end
          // Off-boundary matches here are deliberately ignored so an early
          // copy of the sync word cannot restart the frame count.
          ST_VERIFY: begin
            if (boundary) begin
              bit_cnt <= '0;
              if (match) begin
                if (good == GOOD_LAST) begin
                  state  <= ST_LOCKED;
                  locked <= 1'b1;
                  miss   <= '0;
                  good   <= '0;
                end else begin
                  good <= good + GOOD_ONE;
                end
              end else begin
                state   <= ST_HUNT;
                hunting <= 1'b1;
                good    <= '0;
              end
            end else begin
              bit_cnt <= next_cnt;
            end
          end
          ST_LOCKED: begin
            if (boundary) begin
              bit_cnt <= '0;
              if (match) begin
                miss <= '0;
              end else if (miss == MISS_LAST) begin
                state   <= ST_HUNT;
                locked  <= 1'b0;
                hunting <= 1'b1;
                miss    <= '0;
              end else begin
                miss <= miss + MISS_ONE;
              end
            end else begin
              bit_cnt <= next_cnt;
            end
          end
          default: begin
            state   <= ST_HUNT;
            locked  <= 1'b0;
            hunting <= 1'b1;
            bit_cnt <= '0;
            good    <= '0;
            miss    <= '0;
          end
        endcase
      end
    end
  end

`ifdef UART_SYNC_HUNTER_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      slip_cnt <= '0;
      hit_cnt  <= '0;
      last_err <= '0;
    end else begin
      if ((state == ST_LOCKED) && boundary && !match && (miss == MISS_LAST) &&
          (slip_cnt != 16'hFFFF)) begin
        slip_cnt <= slip_cnt + 16'd1;
      end
      if ((state == ST_LOCKED) && boundary && match && (hit_cnt != 16'hFFFF)) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
      // HUNT has no frame reference, so only tracked boundaries update last_err.
      if ((state != ST_HUNT) && boundary) begin
        last_err <= err;
      end
    end
  end
`endif

endmodule

// File: doc/uart_sync_hunter.md
# uart_sync_hunter

Parametrised frame-sync acquisition block for the UART receive path. It shifts in the received bit stream and detects a configurable sync word with a per-bit compare mask and a programmable bit-error tolerance. A HUNT/VERIFY/LOCKED state machine confirms that sync repeats at the expected frame period before declaring lock, then flywheels through isolated misses. It sits after the bit-recovery stage and drives frame alignment for the downstream deframer.

## Interface
- SYNC_WIDTH, 16: sync word length in bits (≥2).
- FRAME_BITS, 64: bits from the last bit of one sync word to the last bit of the next (≥ SYNC_WIDTH).
- LOCK_CNT, 3: consecutive on-time sync hits, including the first, needed to reach LOCKED (≥1).
- LOSS_CNT, 2: consecutive missed on-time syncs in LOCKED that drop back to HUNT (≥1).
- MAX_ERR, 0: maximum Hamming distance over masked bits still counted as a match.

- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- en  in  1  bit strobe; one received bit per cycle with en=1.
- in_bit  in  1  received bit, valid when en=1.
- ref_sync  in  SYNC_WIDTH  sync pattern; bit 0 is the last bit received.
- ref_mask  in  SYNC_WIDTH  1 = compare this bit, 0 = don't care.
- sync_hit  out  1  pulse: current window matches, in any state.
- frame_start  out  1  pulse: expected frame boundary reached while LOCKED (match or flywheel).
- locked  out  1  level: state is LOCKED.
- hunting  out  1  level: state is HUNT.

## Operation
- Window: new_win = {win[SYNC_WIDTH-2:0], in_bit}. On en=1, win ← new_win. A fill counter saturates at SYNC_WIDTH. The window is valid only once the fill counter has reached SYNC_WIDTH, counting the current bit.
- match = window valid AND popcount((new_win ^ ref_sync) & ref_mask) ≤ MAX_ERR. match is evaluated only on en=1 cycles.
- bit_cnt counts en bits since the last sync end. It is zeroed on every match in HUNT and on every expected boundary in VERIFY or LOCKED. boundary = (bit_cnt == FRAME_BITS-1) with en=1.
- HUNT: match → VERIFY, good=1. If LOCK_CNT==1, match goes directly to LOCKED.
- VERIFY:
  - Matches between boundaries are ignored.
  - At boundary, match → good+1. When good+1 == LOCK_CNT, go to LOCKED and set miss=0.
  - At boundary, no match → HUNT.
- LOCKED:
  - At boundary, frame_start pulses.
  - Match at boundary → miss=0.
  - No match at boundary → miss+1. When miss+1 == LOSS_CNT, go to HUNT.
- The transition into HUNT from VERIFY or LOCKED does not re-evaluate the same cycle's bit as a new sync.
- en=0: win, fill, bit_cnt, state and counters hold.
- ref_sync and ref_mask are treated as quasi-static. A change takes effect on the next en cycle.

## Timing
- All outputs are registered. sync_hit and frame_start assert in the cycle after the en cycle that produced them, for exactly one cycle.
- locked and hunting reflect the state register. They change in the cycle after the deciding en cycle.
- Reset values:
  - state = HUNT
  - win = 0, fill = 0, bit_cnt = 0, good = 0, miss = 0
  - sync_hit = 0, frame_start = 0, locked = 0, hunting = 1
- RST mid-frame or mid-lock forces the reset values on the next edge. The first sync after reset needs SYNC_WIDTH fresh bits.
- Maximum throughput is one bit per cycle with en held high.

## Configuration
- UART_SYNC_HUNTER_STATS_EN defined adds three outputs:
  - slip_cnt, 16 bits: increments on each LOCKED→HUNT transition.
  - hit_cnt, 16 bits: increments on each on-time boundary match in LOCKED.
  - last_err, $clog2(SYNC_WIDTH+1) bits: masked Hamming distance at the latest boundary.
- slip_cnt and hit_cnt saturate at 0xFFFF. All three are cleared by RST.
- Undefined: these ports and their logic are absent, and behaviour is otherwise identical.

## Test plan
- Defaults, ref_sync=0xA5C3, mask=0xFFFF. Send 3 frames of 0xA5C3 followed by 48 random bits, with en=1 every cycle.
  - sync_hit follows each sync; hunting drops after the 1st sync.
  - locked rises 1 cycle after the 3rd sync's last bit.
  - frame_start pulses once per 64 bits thereafter.
- While LOCKED, corrupt 1 sync word, then send a good one → locked stays 1, frame_start still pulses, and the miss counter is cleared. Corrupt 2 consecutive syncs → hunting=1 one cycle after the 2nd boundary.
- MAX_ERR=1: a sync with 1 flipped bit → match. The same sync with 2 flipped bits → no match. mask=0x00FF with the upper byte flipped → match.
- In VERIFY, send a sync copy 10 bits early and then the true sync at the boundary → the early copy pulses sync_hit only, and verification proceeds.
- Insert en=0 gaps of 0–5 cycles between bits → identical state and pulse sequence per bit compared with the gapless run.
- Assert RST while LOCKED with bit_cnt=30 → next cycle locked=0, hunting=1. With ref=0x0000 and full mask, no sync_hit occurs until 16 zero bits have been received.
